// File: rtl/memory_pkg.sv
// memory_pkg: shared types and sizes for the memory_if responder.
//   resp_state_t : responder FSM states (SCRUB after reset, then READY).
//   ADDR_W/DATA_W/DEPTH : geometry of the 256 x 8 byte-addressable array.
package memory_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } resp_state_t;

endpackage

// File: rtl/memory_if.sv
// memory_if: simple single-cycle memory request/response bundle.
//   addr, ren, wen, wdata : driven by the requester.
//   rdata                 : driven by the responder, combinational from addr/ren.
// Handshake: there is no valid/ready pair. A request is the level of ren/wen
// in a cycle; the responder either serves it in that cycle (read data visible
// before the next edge, write committed at the next edge) or ignores it.
// Modports:
//   request  : requester side (DMA copier, bench drivers).
//   response : responder side (memory_responder).
interface memory_if;
    import memory_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              ren;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport request  (output addr, ren, wen, wdata, input  rdata);
    modport response (input  addr, ren, wen, wdata, output rdata);

endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with enable and synchronous clear.
//   CLK, RST : clock, asynchronous active-high reset (count -> 0).
//   en       : increment this cycle.
//   clr      : synchronous clear, wins over en.
//   count    : current value.
//   sat      : high when count is all-ones.
// The counter itself wraps; the owner stops at all-ones by gating en with sat,
// which keeps the saturation decision visible next to the access logic.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: responder end of memory_if backed by a 256 x 8 array.
//   CLK, RST  : clock, asynchronous active-high reset.
//   memif     : memory_if.response (addr/ren/wen/wdata in, rdata out).
//   clr_stats : synchronous clear of rd_count, wr_count and err.
//   init_done : high once the post-reset scrub has written every byte.
//   rd_count  : accepted reads, saturating at all-ones.
//   wr_count  : accepted writes, saturating at all-ones.
//   err       : sticky flag for protocol errors (request during scrub,
//               simultaneous ren/wen, protected write).
// Optional feature macro: WRITE_PROTECT_EN adds parameter WP_LIMIT; writes to
// addresses below it are dropped and flagged. The scrub ignores protection.
module memory_responder
    import memory_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h00,
    parameter int                CNT_W    = 16
`ifdef WRITE_PROTECT_EN
    ,
    parameter logic [ADDR_W-1:0] WP_LIMIT = 8'h10
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    memory_if.response       memif,
    input  logic             clr_stats,
    output logic             init_done,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             err
);

    resp_state_t       state_q, state_d;
    logic [ADDR_W-1:0] scrub_ptr_q, scrub_ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              wr_blocked;
    logic              rd_acc;
    logic              wr_acc;
    logic              err_set;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_sat;
    logic              wr_sat;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= SCRUB;
            scrub_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_ptr_q <= scrub_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_ptr_d = scrub_ptr_q;
        case (state_q)
            SCRUB: begin
                scrub_ptr_d = scrub_ptr_q + 1'b1;
                // Last byte written this cycle; init_done follows at this edge.
                if (&scrub_ptr_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = SCRUB;
            end
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_done = ready;

    // ---------------- Request decode ----------------
`ifdef WRITE_PROTECT_EN
    assign wr_blocked = (memif.addr < WP_LIMIT);
`else
    assign wr_blocked = 1'b0;
`endif

    assign rd_acc  = ready & memif.ren;
    assign wr_acc  = ready & memif.wen & ~wr_blocked;
    assign err_set = (~ready & (memif.ren | memif.wen))
                   | (ready & memif.ren & memif.wen)
                   | (ready & memif.wen & wr_blocked);

    // Read data is combinational so the requester captures it at the next edge.
    // On a simultaneous read/write this still shows the pre-write contents.
    assign memif.rdata = rd_acc ? mem[memif.addr] : '0;

    // ---------------- Array write port ----------------
    // One port shared by the scrub and requester writes; the FSM state picks.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = memif.addr;
        mem_wdata = memif.wdata;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_waddr = scrub_ptr_q;
            mem_wdata = INIT_VAL;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
        end
    end

    // Array has no reset; nothing is committed while RST is held so an
    // in-flight write during reset is lost rather than landing at the edge.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- Sticky error ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (clr_stats) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // ---------------- Access counters ----------------
    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (rd_acc & ~rd_sat),
        .clr   (clr_stats),
        .count (rd_count),
        .sat   (rd_sat)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (wr_acc & ~wr_sat),
        .clr   (clr_stats),
        .count (wr_count),
        .sat   (wr_sat)
    );

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: self-checking bench for memory_responder.
// Inputs change 1 time unit after the rising edge; rdata and registered
// outputs are sampled at the falling edge.
module tb_memory_responder;

    localparam logic [7:0] INIT_VAL = 8'h5A;
    localparam int         CNT_W    = 4;
    localparam int         CNT_MAX  = (1 << CNT_W) - 1;
`ifdef WRITE_PROTECT_EN
    localparam logic [7:0] WP_LIMIT = 8'h10;
    localparam logic [7:0] CP_SRC   = 8'h50;
`else
    localparam logic [7:0] CP_SRC   = 8'h00;
`endif
    localparam logic [7:0] CP_DST   = 8'h80;

    logic             CLK = 1'b0;
    logic             RST;
    logic             clr_stats;
    logic             init_done;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic             err;

    memory_if memif ();

    memory_responder #(
        .INIT_VAL (INIT_VAL),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .memif     (memif),
        .clr_stats (clr_stats),
        .init_done (init_done),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err       (err)
    );

    // ---------------- Clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- Scoreboard and reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] m_mem [256];
    int         m_rd;
    int         m_wr;
    logic       m_err;
    logic       m_ready;
    logic [7:0] last_rd;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic model_reset();
        m_rd    = 0;
        m_wr    = 0;
        m_err   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic model_scrubbed();
        m_ready = 1'b1;
        for (int k = 0; k < 256; k++) m_mem[k] = INIT_VAL;
    endtask

    // One request cycle: drive, push expected rdata, update model, then pop
    // and compare against the DUT at the falling edge.
    task automatic drive(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic c);
        logic [7:0] e;
        logic       wp;
        @(posedge CLK);
        #1;
        memif.ren   = r;
        memif.wen   = w;
        memif.addr  = a;
        memif.wdata = d;
        clr_stats   = c;
        exp_q.push_back((m_ready && r) ? m_mem[a] : 8'h00);
        wp = 1'b0;
`ifdef WRITE_PROTECT_EN
        wp = (a < WP_LIMIT);
`endif
        if (!m_ready) begin
            if (r || w) m_err = 1'b1;
        end else begin
            if (w && !wp) m_mem[a] = d;
            if (r && w) m_err = 1'b1;
            if (w && wp) m_err = 1'b1;
            if (r && m_rd < CNT_MAX) m_rd++;
            if (w && !wp && m_wr < CNT_MAX) m_wr++;
        end
        if (c) begin
            m_rd  = 0;
            m_wr  = 0;
            m_err = 1'b0;
        end
        @(negedge CLK);
        e       = exp_q.pop_front();
        last_rd = memif.rdata;
        n_chk++;
        if (memif.rdata !== e)
            $display("FAIL rdata addr=%02h ren=%0b wen=%0b got=%02h exp=%02h",
                     a, r, w, memif.rdata, e);
        else
            n_pass++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        drive(1'b1, 1'b0, a, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        drive(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    // Release reset at a falling edge and run the 256-cycle scrub, with a
    // read and a write issued while the scrub is in progress.
    task automatic run_scrub();
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int i = 1; i <= 255; i++) begin
            if (i == 10)      rd(8'h33);
            else if (i == 11) wr(8'h02, 8'hEE);
            else              idle();
            if (i == 12) begin
                n_chk++;
                if (err !== 1'b1) $display("FAIL scrub_err got=%0b exp=1", err);
                else n_pass++;
                n_chk++;
                if (rd_count !== '0 || wr_count !== '0)
                    $display("FAIL scrub_counts got=%0d/%0d exp=0/0", rd_count, wr_count);
                else n_pass++;
            end
        end
        n_chk++;
        if (init_done !== 1'b0) $display("FAIL init_done_255 got=%0b exp=0", init_done);
        else n_pass++;
        model_scrubbed();
        idle();
        n_chk++;
        if (init_done !== 1'b1) $display("FAIL init_done_256 got=%0b exp=1", init_done);
        else n_pass++;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        RST         = 1'b1;
        clr_stats   = 1'b0;
        memif.ren   = 1'b1;
        memif.wen   = 1'b0;
        memif.addr  = 8'h05;
        memif.wdata = 8'h00;
        model_reset();
        #3;
        n_chk++;
        if (init_done !== 1'b0 || rd_count !== '0 || wr_count !== '0 || err !== 1'b0)
            $display("FAIL reset_state got=%0b/%0d/%0d/%0b exp=0/0/0/0",
                     init_done, rd_count, wr_count, err);
        else n_pass++;
        n_chk++;
        if (memif.rdata !== 8'h00) $display("FAIL reset_rdata got=%02h exp=00", memif.rdata);
        else n_pass++;
        repeat (2) @(posedge CLK);
        #1;
        n_chk++;
        if (err !== 1'b0) $display("FAIL reset_err_held got=%0b exp=0", err);
        else n_pass++;
        memif.ren = 1'b0;
        run_scrub();
    endtask

    task automatic test_init_read();
        clr();
        rd(8'hA5);
        n_chk++;
        if (last_rd !== INIT_VAL) $display("FAIL init_read got=%02h exp=%02h", last_rd, INIT_VAL);
        else n_pass++;
        idle();
        n_chk++;
        if (rd_count !== CNT_W'(1)) $display("FAIL init_rd_count got=%0d exp=1", rd_count);
        else n_pass++;
        rd(8'h02);
        n_chk++;
        if (last_rd !== INIT_VAL) $display("FAIL scrub_write_ignored got=%02h exp=%02h", last_rd, INIT_VAL);
        else n_pass++;
        rd(8'h33);
    endtask

    task automatic test_write_read();
        clr();
        wr(8'h40, 8'h3C);
        rd(8'h40);
        n_chk++;
        if (last_rd !== 8'h3C) $display("FAIL write_read got=%02h exp=3c", last_rd);
        else n_pass++;
        idle();
        n_chk++;
        if (wr_count !== CNT_W'(1) || rd_count !== CNT_W'(1) || err !== 1'b0)
            $display("FAIL write_read_stats got=%0d/%0d/%0b exp=1/1/0", wr_count, rd_count, err);
        else n_pass++;
    endtask

    task automatic test_rw_collision();
        wr(8'h20, 8'h11);
        clr();
        drive(1'b1, 1'b1, 8'h20, 8'h22, 1'b0);
        n_chk++;
        if (last_rd !== 8'h11) $display("FAIL collide_old got=%02h exp=11", last_rd);
        else n_pass++;
        rd(8'h20);
        n_chk++;
        if (last_rd !== 8'h22) $display("FAIL collide_new got=%02h exp=22", last_rd);
        else n_pass++;
        idle();
        n_chk++;
        if (err !== 1'b1 || rd_count !== CNT_W'(m_rd) || wr_count !== CNT_W'(m_wr))
            $display("FAIL collide_stats got=%0b/%0d/%0d exp=1/%0d/%0d",
                     err, rd_count, wr_count, m_rd, m_wr);
        else n_pass++;
        clr();
        idle();
        n_chk++;
        if (err !== 1'b0 || rd_count !== '0 || wr_count !== '0)
            $display("FAIL clr_stats got=%0b/%0d/%0d exp=0/0/0", err, rd_count, wr_count);
        else n_pass++;
    endtask

    task automatic test_clr_with_access();
        rd(8'h40);
        drive(1'b1, 1'b1, 8'h41, 8'h99, 1'b1);
        idle();
        n_chk++;
        if (err !== 1'b0 || rd_count !== '0 || wr_count !== '0)
            $display("FAIL clr_wins got=%0b/%0d/%0d exp=0/0/0", err, rd_count, wr_count);
        else n_pass++;
        rd(8'h41);
        n_chk++;
        if (last_rd !== 8'h99) $display("FAIL clr_mem_kept got=%02h exp=99", last_rd);
        else n_pass++;
    endtask

    task automatic test_copier();
        logic [7:0] data;
        for (int i = 0; i < 8; i++) wr(8'(CP_SRC + i), 8'(i + 1));
        clr();
        for (int i = 0; i < 8; i++) begin
            rd(8'(CP_SRC + i));
            data = last_rd;
            wr(8'(CP_DST + i), data);
        end
        idle();
        n_chk++;
        if (rd_count !== CNT_W'(8) || wr_count !== CNT_W'(8))
            $display("FAIL copier_counts got=%0d/%0d exp=8/8", rd_count, wr_count);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rd(8'(CP_DST + i));
            n_chk++;
            if (last_rd !== 8'(i + 1))
                $display("FAIL copier_dst[%0d] got=%02h exp=%02h", i, last_rd, 8'(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        clr();
        repeat (CNT_MAX + 2) rd(8'hA5);
        repeat (CNT_MAX + 2) wr(8'h90, 8'h01);
        idle();
        n_chk++;
        if (rd_count !== CNT_W'(CNT_MAX) || wr_count !== CNT_W'(CNT_MAX))
            $display("FAIL saturate got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, CNT_MAX, CNT_MAX);
        else n_pass++;
        rd(8'h90);
        idle();
        n_chk++;
        if (rd_count !== CNT_W'(m_rd)) $display("FAIL saturate_hold got=%0d exp=%0d", rd_count, m_rd);
        else n_pass++;
    endtask

`ifdef WRITE_PROTECT_EN
    task automatic test_write_protect();
        clr();
        wr(8'h05, 8'hFF);
        rd(8'h05);
        n_chk++;
        if (last_rd !== INIT_VAL) $display("FAIL wp_dropped got=%02h exp=%02h", last_rd, INIT_VAL);
        else n_pass++;
        idle();
        n_chk++;
        if (err !== 1'b1 || wr_count !== '0)
            $display("FAIL wp_stats got=%0b/%0d exp=1/0", err, wr_count);
        else n_pass++;
        wr(8'h10, 8'hAB);
        rd(8'h10);
        n_chk++;
        if (last_rd !== 8'hAB) $display("FAIL wp_limit_write got=%02h exp=ab", last_rd);
        else n_pass++;
        idle();
        n_chk++;
        if (wr_count !== CNT_W'(1)) $display("FAIL wp_limit_count got=%0d exp=1", wr_count);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        clr();
        wr(8'hC0, 8'h77);
        drive(1'b1, 1'b1, 8'hC1, 8'h66, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        n_chk++;
        if (init_done !== 1'b0 || rd_count !== '0 || wr_count !== '0 || err !== 1'b0)
            $display("FAIL mid_reset got=%0b/%0d/%0d/%0b exp=0/0/0/0",
                     init_done, rd_count, wr_count, err);
        else n_pass++;
        @(negedge CLK);
        run_scrub();
        rd(8'hC0);
        n_chk++;
        if (last_rd !== INIT_VAL) $display("FAIL mid_reset_rescrub got=%02h exp=%02h", last_rd, INIT_VAL);
        else n_pass++;
    endtask

    // ---------------- Sequence ----------------
    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_rw_collision();
        test_clr_with_access();
        test_copier();
        test_saturation();
`ifdef WRITE_PROTECT_EN
        test_write_protect();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Responder end of the memory_if protocol: a 256 x 8 byte-addressable memory that serves ren/wen/addr/wdata requests and returns rdata.
- Target for the DMA-style copier and any other memory_if requester in lab benches and top-levels.
- Adds a post-reset scrub FSM, saturating access counters and a sticky protocol-error flag for verification visibility.

Parameters:
- INIT_VAL, 8'h00, value written to every byte during the post-reset scrub.
- CNT_W, 16, width of the read and write access counters.

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- memif  modport memory_if.response  —  fields used: addr[7:0], ren, wen, wdata[7:0] (in); rdata[7:0] (out).
- clr_stats  input  1  synchronous clear of rd_count, wr_count and err.
- init_done  output  1  high once the scrub completes; requests are served only while high.
- rd_count  output  CNT_W  number of accepted reads, saturating.
- wr_count  output  CNT_W  number of accepted writes, saturating.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (RST=1, asynchronous): FSM=SCRUB, scrub_ptr=0, init_done=0, rd_count=0, wr_count=0, err=0. Array contents are not reset directly; the scrub writes them. rdata reads 8'h00 while init_done=0.
- FSM states:
  - SCRUB: each cycle write INIT_VAL to mem[scrub_ptr] and increment scrub_ptr (8-bit). After writing address 255, move to READY; init_done rises on the next edge. Scrub takes exactly 256 cycles after RST falls.
  - READY: serve requests. Remains in READY until the next reset.
- Read (READY, ren=1, wen=0): rdata = mem[addr] combinationally, in the same cycle, so a requester may capture it at the next edge. rd_count increments.
- Write (READY, wen=1, ren=0): mem[addr] <= wdata at the rising edge. A read of the same address in the following cycle returns the new value. wr_count increments.
- Idle (ren=0): rdata = 8'h00.
- Simultaneous ren=1 and wen=1: the write is performed. rdata shows the pre-write contents. Both counters increment. err is set.
- Request during SCRUB (ren or wen high while init_done=0): the request is ignored (no write, rdata=0, no count) and err is set.
- Counters saturate at all-ones and never wrap.
- clr_stats=1 zeroes both counters and err at the edge. If an access occurs in the same cycle, clear wins and the access is not counted. clr_stats does not affect memory or the FSM.
- RST asserted mid-operation: all state returns to reset values immediately and the scrub restarts; any in-flight write is lost.
- Addresses are 8-bit and cover the full array; there is no out-of-range case.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- Defined: adds parameter WP_LIMIT (default 8'h10). Writes to addr < WP_LIMIT in READY are dropped: memory unchanged, wr_count not incremented, err set. Reads are unaffected. The scrub ignores protection.
- Undefined: all addresses are writable and WP_LIMIT does not exist.

Decomposition:
- Shared package memory_pkg holds:
  - state enum resp_state_t {SCRUB, READY};
  - localparams ADDR_W=8, DATA_W=8, DEPTH=256.
- memory_if already exists; add a response modport if it is missing.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear, saturate flag). It is instantiated twice for rd_count and wr_count.
- Array, FSM and error logic stay in memory_responder.

Test Plan:
- Reset then wait → init_done rises exactly 256 cycles after RST falls. A read of addr 8'hA5 returns INIT_VAL; rd_count=1.
- Write 8'h3C to 8'h40, then read 8'h40 the next cycle → rdata=8'h3C, wr_count=1, rd_count=1, err=0.
- ren=1 during SCRUB at cycle 10 → err=1, counters 0. After init_done, the target address still holds INIT_VAL.
- ren=wen=1, addr 8'h20 holding 8'h11, wdata 8'h22 → same-cycle rdata=8'h11, next read 8'h22, err=1, both counters incremented. Then clr_stats → counters 0, err 0.
- Copier integration: preload 8'h00..8'h07 with 1..8, copier src=0, dst=8'h80, size=7 → after finished, 8'h80..8'h87 equal 1..8, rd_count=8, wr_count=8.
- WRITE_PROTECT_EN build, WP_LIMIT=8'h10: write 8'hFF to 8'h05 → read returns INIT_VAL, err=1, wr_count unchanged. A write to 8'h10 succeeds.
